// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants, FSM state enum and entry type for fetch_queue
package fetch_queue_pkg;

    localparam logic [31:0] NOP_IR          = 32'h0000_0000;
    localparam int          FQ_DEPTH_DEF    = 4;
    localparam logic [31:0] FQ_RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_store.sv
// rtl/fetch_queue_store.sv - circular entry storage with read/write pointers and occupancy count
module fetch_queue_store
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  fq_entry_t       wdata_i,
    output fq_entry_t       head_o,
    output logic [CW-1:0]   count_o
);

    fq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst && push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch FSM feeding decode; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int          DEPTH    = FQ_DEPTH_DEF,
    parameter  logic [31:0] RESET_PC = FQ_RESET_PC_DEF,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [31:0]     out_ir,
    output logic [31:0]     out_npc,
    output logic [31:0]     out_pc,
    output logic [CW-1:0]   count
);

    fq_state_e      state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    drop_addr_q;
    fq_entry_t      head, resp_entry;
    logic [CW-1:0]  occ, post_cnt;
    logic           resp_take, store_valid, bypass, push, pop;

    assign resp_take   = (state_q == ST_WAIT) && imem_valid && !redirect;
    assign store_valid = (occ != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass      = resp_take && !store_valid && !stall;
`else
    assign bypass      = 1'b0;
`endif
    assign push        = resp_take && !bypass;
    assign pop         = store_valid && !stall && !redirect;
    assign resp_entry  = {fetch_pc_q, fetch_pc_q + 32'd4, imem_data};

    fetch_queue_store #(.DEPTH(DEPTH)) u_store (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (resp_entry),
        .head_o  (head),
        .count_o (occ)
    );

    always_comb begin
        post_cnt = occ;
        if (push && !pop)      post_cnt = occ + CW'(1);
        else if (!push && pop) post_cnt = occ - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!redirect && occ < CW'(DEPTH)) state_d = ST_WAIT;
            ST_WAIT: begin
                if (redirect)        state_d = ST_DROP;
                else if (imem_valid) state_d = (post_cnt < CW'(DEPTH)) ? ST_WAIT : ST_IDLE;
            end
            ST_DROP: if (!redirect && imem_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // While dropping, fetch_pc already holds the new target; keep the old address on the bus.
    always_comb begin
        imem_req  = (state_q != ST_IDLE);
        imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect)       fetch_pc_d = redirect_pc;
        else if (resp_take) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (state_q == ST_WAIT) drop_addr_q <= fetch_pc_q;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_ir    = NOP_IR;
        out_npc   = 32'h0;
        out_pc    = 32'h0;
        if (bypass) begin
            out_valid = 1'b1;
            out_ir    = resp_entry.ir;
            out_npc   = resp_entry.npc;
            out_pc    = resp_entry.pc;
        end else if (store_valid) begin
            out_valid = 1'b1;
            out_ir    = head.ir;
            out_npc   = head.npc;
            out_pc    = head.pc;
        end
    end

    assign count = occ;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_ir, out_npc, out_pc;
    logic [2:0]  count;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_ir      (out_ir),
        .out_npc     (out_npc),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // Stimulus knobs, written only by the main sequence.
    int          valid_pct  = 100;
    int          redir_pct  = 0;
    int          stall_mode = 2;   // 0 random, 1 forced on, 2 forced off
    logic        force_valid = 1'b0;
    int          redir_req  = 0;
    logic [31:0] redir_tgt  = 32'h0;

    // Reference model: instructions decode should still receive, in order.
    ent_t        exp_q[$];
    logic [31:0] fpc;
    logic        stale;
    logic        rst_seen = 1'b0;
    logic        acc_now  = 1'b0;
    ent_t        acc_e;
    logic        bypassed = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory and stimulus driver; model update after each rising edge.
    initial begin : driver
        int          redir_done;
        logic        redir_v, valid_v, req_seen;
        logic [31:0] tgt;
        redir_done = 0;
        forever begin
            @(negedge clk);
            if (rst_seen && rst) begin
                chk("count", 32'(count), 32'(exp_q.size()));
                if (imem_req && !stale) chk("imem_addr", imem_addr, fpc);
            end
            req_seen = imem_req;
            redir_v  = 1'b0;
            tgt      = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | tgt[3:0];
            if (rst) begin
                if (redir_req != redir_done) begin
                    redir_v    = 1'b1;
                    tgt        = redir_tgt;
                    redir_done = redir_req;
                end else if (int'($urandom_range(0, 99)) < redir_pct) begin
                    redir_v = 1'b1;
                end
            end
            valid_v  = force_valid || (rst && imem_req && int'($urandom_range(0, 99)) < valid_pct);
            acc_now  = rst && valid_v && imem_req && !stale && !redir_v;
            acc_e    = '{fpc, fpc + 32'd4, memf(fpc)};
            bypassed = 1'b0;
            case (stall_mode)
                1:       stall = 1'b1;
                2:       stall = 1'b0;
                default: stall = ($urandom_range(0, 99) < 30);
            endcase
            redirect    = redir_v;
            redirect_pc = redir_v ? tgt : $urandom;
            imem_valid  = valid_v;
            imem_data   = imem_req ? memf(imem_addr) : $urandom;

            @(posedge clk);
            #1;
            if (!rst) begin
                rst_seen = 1'b1;
                exp_q.delete();
                fpc   = 32'h0;
                stale = 1'b0;
            end else if (redir_v) begin
                exp_q.delete();
                fpc   = tgt;
                stale = req_seen;
            end else begin
                if (valid_v && stale) stale = 1'b0;
                if (acc_now) begin
                    if (!bypassed) exp_q.push_back(acc_e);
                    fpc = fpc + 32'd4;
                end
            end
        end
    end

    // Monitor: compares what decode sees and retires entries it consumes.
    initial begin : monitor
        logic exp_v, use_byp;
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_seen) begin
                exp_v   = (exp_q.size() != 0);
                use_byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
                if (!exp_v && acc_now && !stall && !redirect) begin
                    exp_v   = 1'b1;
                    use_byp = 1'b1;
                end
`endif
                chk("out_valid", 32'(out_valid), 32'(exp_v));
                if (exp_v) begin
                    e = use_byp ? acc_e : exp_q[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_npc", out_npc, e.npc);
                    chk("out_ir", out_ir, e.ir);
                    if (rst && !stall && !redirect) begin
                        if (use_byp) bypassed = 1'b1;
                        else void'(exp_q.pop_front());
                        pops++;
                    end
                end else begin
                    chk("empty_ir", out_ir, 32'h0);
                    chk("empty_pc", out_pc | out_npc, 32'h0);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_valid = 1'b0; imem_data = 32'h0;
        cycles(3);
        chk("reset_req", 32'(imem_req), 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_ir", out_ir, 32'h0);
        rst = 1'b1;
        cycles(12);

        stall_mode = 1;
        cycles(12);
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_req", 32'(imem_req), 32'h0);
        stall_mode = 2;
        cycles(10);

        valid_pct = 0;
        cycles(2);
        redir_tgt = 32'h100;
        redir_req++;
        cycles(1);
        valid_pct = 100;
        cycles(12);

        redir_tgt = 32'hFFFF_FFF8;
        redir_req++;
        cycles(10);

        valid_pct = 0;
        cycles(3);
        chk("wait_req", 32'(imem_req), 32'h1);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        force_valid = 1'b1;
        cycles(1);
        force_valid = 1'b0;
        valid_pct = 100;
        cycles(10);

        valid_pct = 60; stall_mode = 0; redir_pct = 5;
        cycles(3000);

        valid_pct = 100; stall_mode = 2; redir_pct = 0;
        cycles(20);
        chk("pops_min", 32'(pops >= 200), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
